// File: rtl/osd_dem_uart_16550_rx.sv
// rtl/osd_dem_uart_16550_rx.sv - 16550-style receive register window over a character FIFO
module osd_dem_uart_16550_rx #(
  parameter int FIFO_DEPTH   = 16,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_req,
  input  logic [2:0] bus_addr,
  input  logic       bus_write,
  input  logic [7:0] bus_wdata,
  output logic       bus_ack,
  output logic [7:0] bus_rdata,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  output logic       irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [7:0]    r_lcr;
  logic [2:0]    r_ier;
  logic [7:0]    r_dll;
  logic [7:0]    r_dlm;
  logic [7:0]    r_scr;
  logic          r_oe;
  logic          r_oe_clr;
  logic          r_irq;

  logic       w_dlab;
  logic       w_empty;
  logic       w_full;
  logic       w_rd;
  logic       w_wr;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic       w_flush;
  logic [7:0] w_rbr;
  logic [7:0] w_iir;
  logic [7:0] w_lsr;

  assign w_dlab  = r_lcr[7];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_rd    = bus_req & ~bus_write;
  assign w_wr    = bus_req & bus_write;
  assign w_pop   = w_rd & (bus_addr == 3'd0) & ~w_dlab & ~w_empty;
  assign w_flush = w_wr & (bus_addr == 3'd2) & bus_wdata[1];

  // In drop mode a full FIFO still takes a char when the head leaves this cycle.
  assign w_push   = DROP_ON_FULL ? (in_valid & (~w_full | w_pop)) : (in_valid & ~w_full);
  assign w_drop   = DROP_ON_FULL & in_valid & w_full & ~w_pop;
  assign in_ready = DROP_ON_FULL ? 1'b1 : ~w_full;
  assign bus_ack  = bus_req;
  assign irq      = r_irq;

  assign w_rbr = w_empty ? 8'h00 : r_mem[r_head];
  assign w_lsr = {1'b0, 1'b1, 1'b1, 3'b000, r_oe, ~w_empty};

  always_comb begin
    w_iir = 8'hC1;
    if (r_ier[2] & r_oe) begin
      w_iir = 8'hC6;
    end else if (r_ier[0] & ~w_empty) begin
      w_iir = 8'hC4;
    end
  end

  always_comb begin
    bus_rdata = 8'h00;
    case (bus_addr)
      3'd0:    bus_rdata = w_dlab ? r_dll : w_rbr;
      3'd1:    bus_rdata = w_dlab ? r_dlm : {5'b00000, r_ier};
      3'd2:    bus_rdata = w_iir;
      3'd3:    bus_rdata = r_lcr;
      3'd5:    bus_rdata = w_lsr;
      3'd7:    bus_rdata = r_scr;
      default: bus_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_mem[r_tail] <= in_char;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lcr <= 8'h00;
      r_ier <= 3'b000;
      r_dll <= 8'h00;
      r_dlm <= 8'h00;
      r_scr <= 8'h00;
    end else if (w_wr) begin
      case (bus_addr)
        3'd0: if (w_dlab) r_dll <= bus_wdata;
        3'd1: if (w_dlab) r_dlm <= bus_wdata; else r_ier <= bus_wdata[2:0];
        3'd3: r_lcr <= bus_wdata;
        3'd7: r_scr <= bus_wdata;
        default: ;
      endcase
    end
  end

  // OE is cleared one cycle after an LSR read that returned it set; a new overrun wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oe     <= 1'b0;
      r_oe_clr <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_oe_clr <= w_rd & (bus_addr == 3'd5) & r_oe;
      if (w_drop) begin
        r_oe <= 1'b1;
      end else if (r_oe_clr) begin
        r_oe <= 1'b0;
      end
      r_irq <= (r_ier[2] & r_oe) | (r_ier[0] & ~w_empty);
    end
  end

endmodule

// File: tb/tb_osd_dem_uart_16550_rx.sv
// tb/tb_osd_dem_uart_16550_rx.sv - queue-model bench driving back-pressure and drop-mode instances
module tb_osd_dem_uart_16550_rx;

  logic       clk;
  logic       rst;
  logic       bus_req;
  logic [2:0] bus_addr;
  logic       bus_write;
  logic [7:0] bus_wdata;
  logic       in_valid;
  logic [7:0] in_char;

  logic       ack_w   [2];
  logic [7:0] rdata_w [2];
  logic       ready_w [2];
  logic       irq_w   [2];

  osd_dem_uart_16550_rx #(.FIFO_DEPTH(16), .DROP_ON_FULL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_ack(ack_w[0]), .bus_rdata(rdata_w[0]), .in_valid(in_valid),
    .in_char(in_char), .in_ready(ready_w[0]), .irq(irq_w[0])
  );

  osd_dem_uart_16550_rx #(.FIFO_DEPTH(16), .DROP_ON_FULL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_ack(ack_w[1]), .bus_rdata(rdata_w[1]), .in_valid(in_valid),
    .in_char(in_char), .in_ready(ready_w[1]), .irq(irq_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit started = 0;

  logic [7:0] mq [2][$];
  logic [7:0] m_lcr [2];
  logic [7:0] m_dll [2];
  logic [7:0] m_dlm [2];
  logic [7:0] m_scr [2];
  logic [2:0] m_ier [2];
  logic       m_oe  [2];
  logic       m_oep [2];
  logic       m_irq [2];

  logic [7:0] s_rd  [2];
  logic       s_rdy [2];
  logic       s_irq [2];

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d got %02h expected %02h at %0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rdata(input int i);
    logic [7:0] v;
    v = 8'h00;
    case (bus_addr)
      3'd0: v = m_lcr[i][7] ? m_dll[i] : ((mq[i].size() != 0) ? mq[i][0] : 8'h00);
      3'd1: v = m_lcr[i][7] ? m_dlm[i] : {5'd0, m_ier[i]};
      3'd2: begin
        if (m_ier[i][2] && m_oe[i]) v = 8'hC6;
        else if (m_ier[i][0] && mq[i].size() != 0) v = 8'hC4;
        else v = 8'hC1;
      end
      3'd3: v = m_lcr[i];
      3'd5: v = 8'h60 | (m_oe[i] ? 8'h02 : 8'h00) | ((mq[i].size() != 0) ? 8'h01 : 8'h00);
      3'd7: v = m_scr[i];
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Reference model: a plain queue per instance, updated at each active edge.
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        mq[i].delete();
        m_lcr[i] = 8'h00; m_dll[i] = 8'h00; m_dlm[i] = 8'h00; m_scr[i] = 8'h00;
        m_ier[i] = 3'd0; m_oe[i] = 1'b0; m_oep[i] = 1'b0; m_irq[i] = 1'b0;
      end else begin
        bit rd, wr, full, pop, take, drop, flush;
        rd    = bus_req && !bus_write;
        wr    = bus_req && bus_write;
        full  = (mq[i].size() == 16);
        pop   = rd && bus_addr == 3'd0 && !m_lcr[i][7] && mq[i].size() != 0;
        flush = wr && bus_addr == 3'd2 && bus_wdata[1];
        if (i == 1) begin
          take = in_valid && (!full || pop);
          drop = in_valid && full && !pop;
        end else begin
          take = in_valid && !full;
          drop = 1'b0;
        end
        m_irq[i] = (m_ier[i][2] && m_oe[i]) || (m_ier[i][0] && mq[i].size() != 0);
        if (drop) m_oe[i] = 1'b1;
        else if (m_oep[i]) m_oe[i] = 1'b0;
        m_oep[i] = rd && bus_addr == 3'd5 && (s_lsr_oe_hint(i));
        if (flush) begin
          mq[i].delete();
        end else begin
          if (pop) void'(mq[i].pop_front());
          if (take) mq[i].push_back(in_char);
        end
        if (wr) begin
          case (bus_addr)
            3'd0: if (m_lcr[i][7]) m_dll[i] = bus_wdata;
            3'd1: if (m_lcr[i][7]) m_dlm[i] = bus_wdata; else m_ier[i] = bus_wdata[2:0];
            3'd3: m_lcr[i] = bus_wdata;
            3'd7: m_scr[i] = bus_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // OE value the LSR read returned this cycle, latched before the model edge update.
  logic oe_seen [2];
  function automatic bit s_lsr_oe_hint(input int i);
    return oe_seen[i];
  endfunction

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        oe_seen[i] = m_oe[i];
        chk("ack", i, {7'd0, ack_w[i]}, {7'd0, bus_req});
        chk("in_ready", i, {7'd0, ready_w[i]}, (i == 1) ? 8'h01 : ((mq[i].size() < 16) ? 8'h01 : 8'h00));
        chk("irq", i, {7'd0, irq_w[i]}, {7'd0, m_irq[i]});
        if (bus_req && !bus_write) chk("rdata", i, rdata_w[i], exp_rdata(i));
      end
    end
  end

  task automatic cyc(input logic rq, input logic wr, input logic [2:0] a, input logic [7:0] wd,
                     input logic iv, input logic [7:0] ch);
    bus_req = rq; bus_write = wr; bus_addr = a; bus_wdata = wd; in_valid = iv; in_char = ch;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      s_rd[i] = rdata_w[i]; s_rdy[i] = ready_w[i]; s_irq[i] = irq_w[i];
    end
    @(posedge clk);
    #1;
    bus_req = 1'b0; bus_write = 1'b0; in_valid = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00);
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b1, a, d, 1'b0, 8'h00);
  endtask
  task automatic push(input logic [7:0] c);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, c);
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    oe_seen[0] = 1'b0; oe_seen[1] = 1'b0;
    rst = 1'b0; bus_req = 1'b0; bus_write = 1'b0; bus_addr = 3'd0; bus_wdata = 8'h00;
    in_valid = 1'b0; in_char = 8'h00;
    @(posedge clk);
    started = 1;
    @(posedge clk);
    #1 rst = 1'b1;

    rd(3'd5); chk("rst_lsr", 0, s_rd[0], 8'h60); chk("rst_lsr", 1, s_rd[1], 8'h60);
    rd(3'd2); chk("rst_iir", 0, s_rd[0], 8'hC1);
    rd(3'd0); chk("rst_rbr", 0, s_rd[0], 8'h00);
    chk("rst_ready", 0, {7'd0, s_rdy[0]}, 8'h01); chk("rst_irq", 0, {7'd0, s_irq[0]}, 8'h00);

    push(8'h41); push(8'h42); wr(3'd1, 8'h01); idle();
    rd(3'd5); chk("dr_lsr", 0, s_rd[0], 8'h61); chk("dr_irq", 0, {7'd0, s_irq[0]}, 8'h01);
    rd(3'd0); chk("rbr_a", 0, s_rd[0], 8'h41);
    rd(3'd0); chk("rbr_b", 0, s_rd[0], 8'h42);
    rd(3'd5); chk("empty_lsr", 0, s_rd[0], 8'h60);
    idle(); chk("irq_drop", 0, {7'd0, s_irq[0]}, 8'h00);
    wr(3'd1, 8'h00);

    for (int k = 0; k < 16; k++) push(8'(k));
    push(8'h77); chk("full_ready", 0, {7'd0, s_rdy[0]}, 8'h00);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 8'h77);
    chk("full_pop", 0, s_rd[0], 8'h00); chk("pop_ready", 0, {7'd0, s_rdy[0]}, 8'h00);
    push(8'h77); chk("reopen_ready", 0, {7'd0, s_rdy[0]}, 8'h01);
    for (int k = 0; k < 16; k++) begin
      rd(3'd0);
      chk("wrap_drain", 0, s_rd[0], (k < 15) ? 8'(k + 1) : 8'h77);
    end
    rd(3'd5); idle(); wr(3'd2, 8'h02); idle();

    for (int k = 0; k < 16; k++) push(8'(8'h10 + k));
    push(8'hAA);
    wr(3'd1, 8'h04);
    rd(3'd2); chk("ovr_iir", 1, s_rd[1], 8'hC6); chk("ovr_iir", 0, s_rd[0], 8'hC1);
    rd(3'd5); chk("ovr_lsr", 1, s_rd[1], 8'h63); chk("ovr_lsr", 0, s_rd[0], 8'h61);
    idle();
    rd(3'd5); chk("oe_clr", 1, s_rd[1], 8'h61);
    for (int k = 0; k < 16; k++) begin
      rd(3'd0);
      chk("ovr_drain", 1, s_rd[1], 8'(8'h10 + k));
    end
    wr(3'd1, 8'h00);

    push(8'h55);
    wr(3'd3, 8'h80); wr(3'd0, 8'h12); wr(3'd1, 8'h34);
    rd(3'd0); chk("dll", 0, s_rd[0], 8'h12);
    rd(3'd1); chk("dlm", 0, s_rd[0], 8'h34);
    wr(3'd3, 8'h03);
    rd(3'd3); chk("lcr", 0, s_rd[0], 8'h03);
    rd(3'd5); chk("dlab_cnt", 0, s_rd[0], 8'h61);
    rd(3'd0); chk("dlab_rbr", 0, s_rd[0], 8'h55);
    wr(3'd7, 8'h5A); rd(3'd7); chk("scr", 0, s_rd[0], 8'h5A);

    push(8'h01); push(8'h02); push(8'h03);
    cyc(1'b1, 1'b1, 3'd2, 8'h02, 1'b1, 8'h99);
    rd(3'd5); chk("flush_lsr", 0, s_rd[0], 8'h60); chk("flush_lsr", 1, s_rd[1], 8'h60);
    rd(3'd0); chk("flush_rbr", 0, s_rd[0], 8'h00);

    push(8'h21); push(8'h22); wr(3'd1, 8'h05);
    rst = 1'b0;
    idle(); idle();
    rst = 1'b1;
    rd(3'd5); chk("mid_rst_lsr", 0, s_rd[0], 8'h60);
    rd(3'd7); chk("mid_rst_scr", 0, s_rd[0], 8'h00);

    for (int n = 0; n < 4000; n++) begin
      logic rq, w, iv;
      logic [2:0] a;
      logic [7:0] d;
      rq = ($urandom_range(0, 9) < ((n < 2000) ? 4 : 7));
      w  = rq && ($urandom_range(0, 9) < 3);
      a  = 3'($urandom_range(0, 7));
      if (rq && !w && n >= 2000 && $urandom_range(0, 1) == 1) a = 3'd0;
      d  = 8'($urandom);
      if (w && a == 3'd3 && $urandom_range(0, 4) != 0) d[7] = 1'b0;
      if (w && a == 3'd2 && $urandom_range(0, 2) != 0) d[1] = 1'b0;
      iv = ($urandom_range(0, 9) < ((n < 2000) ? 7 : 4));
      cyc(rq, w, a, d, iv, 8'($urandom));
      if (n == 3000) begin
        rst = 1'b0;
        idle();
        rst = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
